lsu: RTL and testbench

//  Load/store unit between the datapath and data memory; producer of the mem_data writeback operand.

---
 rtl/rv32_pkg.sv | 33 +++
 rtl/lsu_if.sv | 19 +
 rtl/lsu_load_align.sv | 31 +++
 rtl/lsu.sv | 200 ++++++++++++++++++++
 tb/tb_lsu.sv | 218 +++++++++++++++++++++
 5 files changed

// File: rtl/rv32_pkg.sv
`default_nettype none
// ============================================================================
// Module   : rv32_pkg
// Brief    : Shared RV32I load/store funct3 codes and LSU FSM state encoding.
// Revision : 1.0 - initial release
// ============================================================================
package rv32_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_DONE = 2'd2
    } lsu_state_e;

    function automatic logic funct3_legal(input logic store, input logic [2:0] f3);
        if (store) begin
            return (f3 == F3_SB) || (f3 == F3_SH) || (f3 == F3_SW);
        end
        return (f3 == F3_LB) || (f3 == F3_LH) || (f3 == F3_LW) ||
               (f3 == F3_LBU) || (f3 == F3_LHU);
    endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_if.sv
`default_nettype none
// ============================================================================
// Module   : lsu_if
// Brief    : Data-memory req/ack bus between the LSU (master) and memory (slave).
// Revision : 1.0 - initial release
// ============================================================================
interface lsu_if;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        ack;

    modport master (output req, we, addr, be, wdata, input rdata, ack);
    modport slave  (input req, we, addr, be, wdata, output rdata, ack);
endinterface
`default_nettype wire

// File: rtl/lsu_load_align.sv
`default_nettype none
// ============================================================================
// Module   : lsu_load_align
// Brief    : Selects the load lane from a read word and sign/zero-extends it.
// Revision : 1.0 - initial release
// ============================================================================
module lsu_load_align
    import rv32_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] rdata,
    output logic [31:0] data
);
    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte = rdata[8*addr_lo +: 8];
        w_half = addr_lo[1] ? rdata[31:16] : rdata[15:0];
        case (funct3)
            F3_LB:   data = {{24{w_byte[7]}}, w_byte};
            F3_LBU:  data = {24'b0, w_byte};
            F3_LH:   data = {{16{w_half[15]}}, w_half};
            F3_LHU:  data = {16'b0, w_half};
            F3_LW:   data = rdata;
            default: data = 32'b0;
        endcase
    end
endmodule
`default_nettype wire

// File: rtl/lsu.sv
`default_nettype none
// ============================================================================
// Module   : lsu
// Brief    : Load/store unit: one req/ack memory access per instruction, with
//            lane placement, load extension, core stall and ack timeout.
//            LSU_MISALIGN_TRAP_EN: trap misaligned accesses instead of aligning.
// Revision : 1.0 - initial release
// ============================================================================
module lsu
    import rv32_pkg::*;
#(
    parameter int ACK_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        lsu_valid,
    input  logic        lsu_store,
    input  logic [2:0]  lsu_funct3,
    input  logic [31:0] lsu_addr,
    input  logic [31:0] lsu_wdata,
    output logic        lsu_stall,
    output logic        lsu_done,
    output logic [31:0] lsu_load_data,
    output logic        lsu_bus_err,
    output logic        lsu_misalign,
    lsu_if.master       dmem
);
    localparam int CNT_W = $clog2(ACK_TIMEOUT);

    lsu_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       funct3_q, funct3_d;
    logic [1:0]       addr_lo_q, addr_lo_d;
    logic             store_q, store_d;
    logic [31:0]      load_data_q, load_data_d;
    logic             bus_err_q, bus_err_d;
    logic             misalign_q, misalign_d;
    logic             req_q, req_d;
    logic             we_q, we_d;
    logic [29:0]      addr_q, addr_d;
    logic [3:0]       be_q, be_d;
    logic [31:0]      wdata_q, wdata_d;

    logic [1:0]       w_lo;
    logic             w_trap;
    logic [3:0]       w_be;
    logic [31:0]      w_wdata;
    logic [31:0]      w_ext;

    // Lane offset actually used for the access; untrapped builds drop the low bits.
    always_comb begin
`ifdef LSU_MISALIGN_TRAP_EN
        w_lo   = lsu_addr[1:0];
        w_trap = ((lsu_funct3[1:0] == 2'b01) && lsu_addr[0]) ||
                 ((lsu_funct3[1:0] == 2'b10) && (lsu_addr[1:0] != 2'b00));
`else
        w_trap = 1'b0;
        case (lsu_funct3[1:0])
            2'b01:   w_lo = {lsu_addr[1], 1'b0};
            2'b10:   w_lo = 2'b00;
            default: w_lo = lsu_addr[1:0];
        endcase
`endif
    end

    always_comb begin
        case (lsu_funct3[1:0])
            2'b00: begin
                w_be    = 4'b0001 << w_lo;
                w_wdata = {4{lsu_wdata[7:0]}};
            end
            2'b01: begin
                w_be    = w_lo[1] ? 4'b1100 : 4'b0011;
                w_wdata = {2{lsu_wdata[15:0]}};
            end
            default: begin
                w_be    = 4'b1111;
                w_wdata = lsu_wdata;
            end
        endcase
    end

    lsu_load_align u_load_align (
        .funct3  (funct3_q),
        .addr_lo (addr_lo_q),
        .rdata   (dmem.rdata),
        .data    (w_ext)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        funct3_d    = funct3_q;
        addr_lo_d   = addr_lo_q;
        store_d     = store_q;
        load_data_d = load_data_q;
        bus_err_d   = bus_err_q;
        misalign_d  = misalign_q;
        req_d       = req_q;
        we_d        = we_q;
        addr_d      = addr_q;
        be_d        = be_q;
        wdata_d     = wdata_q;
        case (state_q)
            S_IDLE: begin
                bus_err_d  = 1'b0;
                misalign_d = 1'b0;
                if (lsu_valid) begin
                    funct3_d  = lsu_funct3;
                    store_d   = lsu_store;
                    addr_lo_d = w_lo;
                    if (!funct3_legal(lsu_store, lsu_funct3)) begin
                        state_d     = S_DONE;
                        load_data_d = 32'b0;
                    end else if (w_trap) begin
                        state_d     = S_DONE;
                        misalign_d  = 1'b1;
                        load_data_d = 32'b0;
                    end else begin
                        state_d = S_REQ;
                        cnt_d   = '0;
                        req_d   = 1'b1;
                        we_d    = lsu_store;
                        addr_d  = lsu_addr[31:2];
                        be_d    = lsu_store ? w_be : 4'b1111;
                        wdata_d = lsu_store ? w_wdata : 32'b0;
                    end
                end
            end
            S_REQ: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (dmem.ack) begin
                    state_d = S_DONE;
                    req_d   = 1'b0;
                    if (!store_q) begin
                        load_data_d = w_ext;
                    end
                end else if (cnt_q == CNT_W'(ACK_TIMEOUT - 1)) begin
                    state_d     = S_DONE;
                    req_d       = 1'b0;
                    bus_err_d   = 1'b1;
                    load_data_d = 32'b0;
                end
            end
            S_DONE: begin
                state_d    = S_IDLE;
                bus_err_d  = 1'b0;
                misalign_d = 1'b0;
            end
            default: begin
                state_d = S_IDLE;
                req_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            funct3_q    <= 3'b0;
            addr_lo_q   <= 2'b0;
            store_q     <= 1'b0;
            load_data_q <= 32'b0;
            bus_err_q   <= 1'b0;
            misalign_q  <= 1'b0;
            req_q       <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= 30'b0;
            be_q        <= 4'b0;
            wdata_q     <= 32'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            funct3_q    <= funct3_d;
            addr_lo_q   <= addr_lo_d;
            store_q     <= store_d;
            load_data_q <= load_data_d;
            bus_err_q   <= bus_err_d;
            misalign_q  <= misalign_d;
            req_q       <= req_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            be_q        <= be_d;
            wdata_q     <= wdata_d;
        end
    end

    assign lsu_done      = (state_q == S_DONE);
    assign lsu_stall     = lsu_valid & ~lsu_done;
    assign lsu_load_data = load_data_q;
    assign lsu_bus_err   = bus_err_q & lsu_done;
    assign lsu_misalign  = misalign_q & lsu_done;
    assign dmem.req      = req_q;
    assign dmem.we       = we_q;
    assign dmem.addr     = {addr_q, 2'b00};
    assign dmem.be       = be_q;
    assign dmem.wdata    = wdata_q;
endmodule
`default_nettype wire

// File: tb/tb_lsu.sv
`default_nettype none
// ============================================================================
// Module   : tb_lsu
// Brief    : Self-checking bench for lsu: directed cases plus random accesses
//            against an arithmetic reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lsu;
    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        lsu_valid = 1'b0;
    logic        lsu_store = 1'b0;
    logic [2:0]  lsu_funct3 = 3'b0;
    logic [31:0] lsu_addr = 32'b0;
    logic [31:0] lsu_wdata = 32'b0;
    logic        lsu_stall, lsu_done, lsu_bus_err, lsu_misalign;
    logic [31:0] lsu_load_data;

    int errors = 0;
    int checks = 0;
    logic [31:0] exp_ld = 32'b0;

    always #5 clk = ~clk;

    lsu_if bus ();

    lsu #(.ACK_TIMEOUT(TO)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .lsu_valid     (lsu_valid),
        .lsu_store     (lsu_store),
        .lsu_funct3    (lsu_funct3),
        .lsu_addr      (lsu_addr),
        .lsu_wdata     (lsu_wdata),
        .lsu_stall     (lsu_stall),
        .lsu_done      (lsu_done),
        .lsu_load_data (lsu_load_data),
        .lsu_bus_err   (lsu_bus_err),
        .lsu_misalign  (lsu_misalign),
        .dmem          (bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: sizes, lanes and extension computed with plain arithmetic.
    function automatic void model(input bit st, input logic [2:0] f3,
                                  input logic [31:0] a, input logic [31:0] wd,
                                  input logic [31:0] rd,
                                  output bit legal, output bit trap,
                                  output logic [31:0] waddr, output logic [3:0] be,
                                  output logic [31:0] wdo, output logic [31:0] ld);
        int unsigned size;
        int unsigned lo;
        logic [31:0] eff;
        logic [31:0] v;
        legal = st ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        size  = 1 << f3[1:0];
        trap  = 1'b0;
        eff   = a;
        if ((a % size) != 0) begin
`ifdef LSU_MISALIGN_TRAP_EN
            trap = 1'b1;
`else
            eff = a - (a % size);
`endif
        end
        waddr = eff & ~32'h3;
        lo    = eff % 4;
        be    = st ? 4'(((1 << size) - 1) << lo) : 4'hF;
        if (size == 1)      wdo = {24'b0, wd[7:0]} * 32'h01010101;
        else if (size == 2) wdo = {16'b0, wd[15:0]} * 32'h00010001;
        else                wdo = wd;
        v = rd >> (8 * lo);
        if (size == 1) begin
            ld = v & 32'hFF;
            if (!f3[2] && v[7]) ld = ld | 32'hFFFFFF00;
        end else if (size == 2) begin
            ld = v & 32'hFFFF;
            if (!f3[2] && v[15]) ld = ld | 32'hFFFF0000;
        end else begin
            ld = rd;
        end
    endfunction

    // dly<0: never acknowledge (timeout path).
    task automatic access(input bit st, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd, input logic [31:0] rd,
                          input int dly, input string tag);
        bit legal, trap, go, done_seen;
        logic [31:0] waddr, wdo, ld;
        logic [3:0] be;
        int n, reqn, exp_n, exp_reqn;
        model(st, f3, a, wd, rd, legal, trap, waddr, be, wdo, ld);
        go       = legal && !trap;
        exp_reqn = go ? ((dly >= 0) ? dly + 1 : TO) : 0;
        exp_n    = go ? exp_reqn + 1 : 1;
        @(negedge clk);
        lsu_valid  = 1'b1;
        lsu_store  = st;
        lsu_funct3 = f3;
        lsu_addr   = a;
        lsu_wdata  = wd;
        n = 0;
        reqn = 0;
        done_seen = 1'b0;
        while (!done_seen && n < 60) begin
            @(negedge clk);
            n++;
            bus.ack   = 1'b0;
            bus.rdata = $urandom;
            if (lsu_done) begin
                done_seen = 1'b1;
            end else begin
                chk({tag, " stall"}, {31'b0, lsu_stall}, 32'd1);
                if (bus.req) begin
                    reqn++;
                    if (reqn == 1) begin
                        chk({tag, " addr"}, bus.addr, waddr);
                        chk({tag, " we"}, {31'b0, bus.we}, {31'b0, st});
                        chk({tag, " be"}, {28'b0, bus.be}, {28'b0, be});
                        if (st) chk({tag, " wdata"}, bus.wdata, wdo);
                    end
                    if (dly >= 0 && reqn - 1 == dly) begin
                        bus.ack   = 1'b1;
                        bus.rdata = rd;
                    end
                end
            end
        end
        chk({tag, " done_seen"}, {31'b0, done_seen}, 32'd1);
        chk({tag, " latency"}, n, exp_n);
        chk({tag, " req_cycles"}, reqn, exp_reqn);
        if (!legal || trap || (go && dly < 0)) exp_ld = 32'b0;
        else if (!st) exp_ld = ld;
        chk({tag, " stall_at_done"}, {31'b0, lsu_stall}, 32'd0);
        chk({tag, " req_at_done"}, {31'b0, bus.req}, 32'd0);
        chk({tag, " bus_err"}, {31'b0, lsu_bus_err}, {31'b0, go && dly < 0});
        chk({tag, " misalign"}, {31'b0, lsu_misalign}, {31'b0, legal && trap});
        chk({tag, " load_data"}, lsu_load_data, exp_ld);
        lsu_valid = 1'b0;
    endtask

    initial begin
        bus.ack   = 1'b0;
        bus.rdata = 32'b0;
        repeat (2) @(negedge clk);
        chk("rst req", {31'b0, bus.req}, 32'd0);
        chk("rst done", {31'b0, lsu_done}, 32'd0);
        chk("rst stall", {31'b0, lsu_stall}, 32'd0);
        chk("rst load_data", lsu_load_data, 32'd0);
        chk("rst bus_err", {31'b0, lsu_bus_err}, 32'd0);
        chk("rst misalign", {31'b0, lsu_misalign}, 32'd0);
        chk("rst be", {28'b0, bus.be}, 32'd0);
        chk("rst addr", bus.addr, 32'd0);
        rst_n = 1'b1;

        access(1'b0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 0, "LW");
        chk("LW value", lsu_load_data, 32'hDEADBEEF);
        access(1'b0, 3'b000, 32'h103, 32'h0, 32'h80123456, 1, "LB");
        chk("LB value", lsu_load_data, 32'hFFFFFF80);
        access(1'b0, 3'b100, 32'h103, 32'h0, 32'h80123456, 2, "LBU");
        chk("LBU value", lsu_load_data, 32'h00000080);
        access(1'b0, 3'b101, 32'h102, 32'h0, 32'h80AB1234, 0, "LHU");
        chk("LHU value", lsu_load_data, 32'h000080AB);
        access(1'b1, 3'b000, 32'h201, 32'h000000AB, 32'h0, 0, "SB");
        access(1'b1, 3'b001, 32'h202, 32'h1234CDEF, 32'h0, 3, "SH");
        access(1'b0, 3'b010, 32'h104, 32'h0, 32'h55AA55AA, 0, "LW2");
        access(1'b0, 3'b010, 32'h108, 32'h0, 32'h0, -1, "TIMEOUT");
        access(1'b0, 3'b010, 32'h102, 32'h0, 32'h13579BDF, 0, "LW_MISAL");
        access(1'b0, 3'b011, 32'h100, 32'h0, 32'h0, 0, "ILL_LD");
        access(1'b1, 3'b100, 32'h100, 32'h0, 32'h0, 0, "ILL_ST");

        // Reset in the middle of a request.
        access(1'b0, 3'b010, 32'h100, 32'h0, 32'hCAFEF00D, 0, "PRE_RST");
        @(negedge clk);
        lsu_valid  = 1'b1;
        lsu_store  = 1'b0;
        lsu_funct3 = 3'b010;
        lsu_addr   = 32'h300;
        repeat (2) @(negedge clk);
        chk("mid req high", {31'b0, bus.req}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid rst req", {31'b0, bus.req}, 32'd0);
        chk("mid rst load_data", lsu_load_data, 32'd0);
        exp_ld    = 32'b0;
        lsu_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        bus.ack = 1'b1;
        bus.rdata = 32'hFFFFFFFF;
        @(negedge clk);
        bus.ack = 1'b0;
        @(negedge clk);
        chk("stray ack req", {31'b0, bus.req}, 32'd0);
        chk("stray ack done", {31'b0, lsu_done}, 32'd0);
        chk("stray ack load_data", lsu_load_data, 32'd0);
        access(1'b0, 3'b010, 32'h100, 32'h0, 32'h01234567, 0, "POST_RST");

        for (int i = 0; i < 80; i++) begin
            access(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom, $urandom,
                   $urandom, ($urandom_range(0, 9) == 0) ? -1 : int'($urandom_range(0, 3)),
                   "RND");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire
